// File: rtl/cpu64_l2_probe_sched.sv
`default_nettype none
// ============================================================================
// Module   : cpu64_l2_probe_sched
// Brief    : L2 probe-round scheduler. Issues TileLink B-channel Probe
//            messages to a masked set of L1 clients (lowest index first),
//            collects ProbeAck/ProbeAckData responses, flags dirty data and
//            spurious acks, and pulses done when every client has answered.
// Revision : 1.0 - initial release
// ============================================================================
module cpu64_l2_probe_sched #(
  parameter int CORES  = 4,
  parameter int ADDR_W = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  // Probe-round request
  input  logic                     start_i,
  input  logic [CORES-1:0]         start_mask_i,
  input  logic [ADDR_W-1:0]        start_addr_i,
  input  logic [1:0]               start_param_i,
  output logic                     start_ready_o,
  // B channel
  output logic                     b_valid_o,
  input  logic                     b_ready_i,
  output logic [2:0]               b_opcode_o,
  output logic [1:0]               b_param_o,
  output logic [ADDR_W-1:0]        b_address_o,
  output logic [$clog2(CORES)-1:0] b_dest_o,
  // Acks already accepted on the C channel
  input  logic                     ack_valid_i,
  input  logic [$clog2(CORES)-1:0] ack_id_i,
  input  logic                     ack_data_i,
  // Status
  output logic                     busy_o,
  output logic [CORES-1:0]         pending_o,
  output logic                     done_o,
  output logic                     dirty_o,
  output logic                     err_o
);

  localparam int       DEST_W    = $clog2(CORES);
  localparam logic [2:0] OPC_PROBE = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CORES-1:0]    to_send_q, to_send_d;
  logic [CORES-1:0]    pending_q, pending_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          param_q, param_d;
  logic                dirty_q, dirty_d;

  logic [DEST_W-1:0]   dest;
  logic                accept;
  logic                b_hs;
  logic                ack_ok;
  logic [CORES-1:0]    sent_oh;
  logic [CORES-1:0]    ack_oh;

  // Lowest-index outstanding probe target; only changes on a handshake, so
  // it is stable while the B beat is stalled.
  always_comb begin
    dest = '0;
    for (int i = CORES - 1; i >= 0; i--) begin
      if (to_send_q[i]) dest = DEST_W'(i);
    end
  end

  // Handshake and ack qualification; an ack for a core whose probe has not
  // yet left (including one leaving this very cycle) counts as spurious.
  always_comb begin
    accept  = start_i && (state_q == S_IDLE);
    b_hs    = (state_q == S_SEND) && b_ready_i;
    ack_ok  = ack_valid_i && pending_q[ack_id_i] && !to_send_q[ack_id_i] &&
              ((state_q == S_SEND) || (state_q == S_WAIT));
    sent_oh = '0;
    sent_oh[dest] = b_hs;
    ack_oh  = '0;
    ack_oh[ack_id_i] = ack_ok;
  end

  // Next-state and datapath update for the probe round.
  always_comb begin
    state_d   = state_q;
    to_send_d = to_send_q;
    pending_d = pending_q;
    addr_d    = addr_q;
    param_d   = param_q;
    dirty_d   = dirty_q;

    if (ack_ok && ack_data_i) dirty_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d    = start_addr_i;
          param_d   = start_param_i;
          to_send_d = start_mask_i;
          pending_d = start_mask_i;
          dirty_d   = 1'b0;
          state_d   = (start_mask_i == '0) ? S_DONE : S_SEND;
        end
      end
      S_SEND: begin
        to_send_d = to_send_q & ~sent_oh;
        pending_d = pending_q & ~ack_oh;
        if (to_send_d == '0) begin
          state_d = (pending_d == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        pending_d = pending_q & ~ack_oh;
        if (pending_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and round-context registers; reset aborts any round in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      to_send_q <= '0;
      pending_q <= '0;
      addr_q    <= '0;
      param_q   <= '0;
      dirty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_send_q <= to_send_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      param_q   <= param_d;
      dirty_q   <= dirty_d;
    end
  end

  assign start_ready_o = (state_q == S_IDLE);
  assign b_valid_o     = (state_q == S_SEND);
  assign b_opcode_o    = OPC_PROBE;
  assign b_param_o     = param_q;
  assign b_address_o   = addr_q;
  assign b_dest_o      = dest;
  assign busy_o        = (state_q != S_IDLE);
  assign pending_o     = pending_q;
  assign done_o        = (state_q == S_DONE);
  assign dirty_o       = dirty_q;
  assign err_o         = ack_valid_i && !ack_ok;

endmodule
`default_nettype wire

// File: tb/tb_cpu64_l2_probe_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu64_l2_probe_sched
// Brief    : Directed self-checking bench for cpu64_l2_probe_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu64_l2_probe_sched;

  localparam int CORES  = 4;
  localparam int ADDR_W = 64;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              start_i;
  logic [CORES-1:0]  start_mask_i;
  logic [ADDR_W-1:0] start_addr_i;
  logic [1:0]        start_param_i;
  logic              start_ready_o;
  logic              b_valid_o;
  logic              b_ready_i;
  logic [2:0]        b_opcode_o;
  logic [1:0]        b_param_o;
  logic [ADDR_W-1:0] b_address_o;
  logic [1:0]        b_dest_o;
  logic              ack_valid_i;
  logic [1:0]        ack_id_i;
  logic              ack_data_i;
  logic              busy_o;
  logic [CORES-1:0]  pending_o;
  logic              done_o;
  logic              dirty_o;
  logic              err_o;

  int checks = 0;
  int errors = 0;

  cpu64_l2_probe_sched #(.CORES(CORES), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .start_i(start_i), .start_mask_i(start_mask_i), .start_addr_i(start_addr_i),
    .start_param_i(start_param_i), .start_ready_o(start_ready_o),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_opcode_o(b_opcode_o),
    .b_param_o(b_param_o), .b_address_o(b_address_o), .b_dest_o(b_dest_o),
    .ack_valid_i(ack_valid_i), .ack_id_i(ack_id_i), .ack_data_i(ack_data_i),
    .busy_o(busy_o), .pending_o(pending_o), .done_o(done_o),
    .dirty_o(dirty_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b0; start_mask_i = '0; start_addr_i = '0;
    start_param_i = '0; b_ready_i = 1'b0; ack_valid_i = 1'b0; ack_id_i = '0;
    ack_data_i = 1'b0;
    #12;
    checks++; if (start_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", start_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy_o); end
    checks++; if (b_valid_o !== 1'b0) begin errors++; $display("FAIL rst_bvalid: got %b exp 0", b_valid_o); end
    checks++; if (pending_o !== 4'b0000) begin errors++; $display("FAIL rst_pending: got %b exp 0000", pending_o); end
    checks++; if ({done_o, dirty_o, err_o} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b exp 000", {done_o, dirty_o, err_o}); end
    checks++; if ({b_dest_o, b_param_o} !== 4'h0 || b_address_o !== 64'h0) begin errors++; $display("FAIL rst_regs: got dest %0d param %0d addr %h exp 0", b_dest_o, b_param_o, b_address_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    #4;
    // Ack arriving in IDLE is spurious.
    ack_valid_i = 1'b1; ack_id_i = 2'd0; #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL idle_ack_err: got %b exp 1", err_o); end
    tick();
    ack_valid_i = 1'b0; #1;
    checks++; if (pending_o !== 4'b0000 || busy_o !== 1'b0) begin errors++; $display("FAIL idle_ack_state: got pend %b busy %b exp 0000 0", pending_o, busy_o); end
  endtask

  task automatic test_basic();
    start_i = 1'b1; start_mask_i = 4'b1010; start_addr_i = 64'h1000;
    start_param_i = 2'd2; b_ready_i = 1'b1; #1;
    checks++; if (start_ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b exp 1", start_ready_o); end
    tick();
    start_i = 1'b0; #1;
    checks++; if (b_valid_o !== 1'b1 || b_dest_o !== 2'd1) begin errors++; $display("FAIL basic_probe1: got v %b dest %0d exp 1 1", b_valid_o, b_dest_o); end
    checks++; if (b_opcode_o !== 3'd6 || b_param_o !== 2'd2 || b_address_o !== 64'h1000) begin errors++; $display("FAIL basic_fields: got op %0d par %0d addr %h exp 6 2 1000", b_opcode_o, b_param_o, b_address_o); end
    checks++; if (pending_o !== 4'b1010 || busy_o !== 1'b1) begin errors++; $display("FAIL basic_pend: got %b busy %b exp 1010 1", pending_o, busy_o); end
    tick();
    checks++; if (b_valid_o !== 1'b1 || b_dest_o !== 2'd3) begin errors++; $display("FAIL basic_probe2: got v %b dest %0d exp 1 3", b_valid_o, b_dest_o); end
    tick();
    checks++; if (b_valid_o !== 1'b0 || pending_o !== 4'b1010) begin errors++; $display("FAIL basic_wait: got v %b pend %b exp 0 1010", b_valid_o, pending_o); end
    ack_valid_i = 1'b1; ack_id_i = 2'd3; #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL basic_ack3_err: got %b exp 0", err_o); end
    tick();
    ack_id_i = 2'd1; #1;
    checks++; if (pending_o !== 4'b0010 || done_o !== 1'b0) begin errors++; $display("FAIL basic_after_ack3: got pend %b done %b exp 0010 0", pending_o, done_o); end
    tick();
    ack_valid_i = 1'b0; #1;
    checks++; if (done_o !== 1'b1 || dirty_o !== 1'b0 || pending_o !== 4'b0000) begin errors++; $display("FAIL basic_done: got done %b dirty %b pend %b exp 1 0 0000", done_o, dirty_o, pending_o); end
    tick();
    checks++; if (done_o !== 1'b0 || start_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL basic_idle: got done %b rdy %b busy %b exp 0 1 0", done_o, start_ready_o, busy_o); end
  endtask

  task automatic test_stall();
    start_i = 1'b1; start_mask_i = 4'b0001; start_addr_i = 64'hABC0;
    start_param_i = 2'd1; b_ready_i = 1'b0;
    tick();
    start_i = 1'b0; start_addr_i = 64'hFFFF; start_param_i = 2'd3;
    for (int c = 0; c < 5; c++) begin
      checks++; if (b_valid_o !== 1'b1 || b_dest_o !== 2'd0 || b_address_o !== 64'hABC0 || b_param_o !== 2'd1) begin errors++; $display("FAIL stall_hold%0d: got v %b dest %0d addr %h par %0d exp 1 0 abc0 1", c, b_valid_o, b_dest_o, b_address_o, b_param_o); end
      tick();
    end
    b_ready_i = 1'b1;
    tick();
    b_ready_i = 1'b0; ack_valid_i = 1'b1; ack_id_i = 2'd0; ack_data_i = 1'b1;
    tick();
    ack_valid_i = 1'b0; ack_data_i = 1'b0; #1;
    checks++; if (done_o !== 1'b1 || dirty_o !== 1'b1) begin errors++; $display("FAIL stall_done: got done %b dirty %b exp 1 1", done_o, dirty_o); end
    tick();
    checks++; if (dirty_o !== 1'b1 || start_ready_o !== 1'b1) begin errors++; $display("FAIL stall_dirty_hold: got dirty %b rdy %b exp 1 1", dirty_o, start_ready_o); end
  endtask

  task automatic test_zero_mask();
    start_i = 1'b1; start_mask_i = 4'b0000; b_ready_i = 1'b1;
    tick();
    start_i = 1'b0; #1;
    checks++; if (done_o !== 1'b1 || b_valid_o !== 1'b0 || dirty_o !== 1'b0) begin errors++; $display("FAIL zero_done: got done %b v %b dirty %b exp 1 0 0", done_o, b_valid_o, dirty_o); end
    tick();
    checks++; if (start_ready_o !== 1'b1 || done_o !== 1'b0 || b_valid_o !== 1'b0) begin errors++; $display("FAIL zero_idle: got rdy %b done %b v %b exp 1 0 0", start_ready_o, done_o, b_valid_o); end
  endtask

  task automatic test_spurious_and_concurrent();
    start_i = 1'b1; start_mask_i = 4'b0110; start_addr_i = 64'h40; start_param_i = 2'd0;
    b_ready_i = 1'b0;
    tick();
    start_i = 1'b0;
    ack_valid_i = 1'b1; ack_id_i = 2'd0; #1;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL spur_ack0_err: got %b exp 1", err_o); end
    tick();
    ack_id_i = 2'd2; #1;
    checks++; if (err_o !== 1'b1 || pending_o !== 4'b0110) begin errors++; $display("FAIL spur_unsent: got err %b pend %b exp 1 0110", err_o, pending_o); end
    tick();
    // Handshake to core 1 with an ack from core 1 in the same cycle.
    b_ready_i = 1'b1; ack_id_i = 2'd1; #1;
    checks++; if (err_o !== 1'b1 || pending_o !== 4'b0110) begin errors++; $display("FAIL spur_same: got err %b pend %b exp 1 0110", err_o, pending_o); end
    tick();
    // Handshake to core 2 with a valid ack from core 1 in the same cycle.
    #1;
    checks++; if (b_dest_o !== 2'd2 || pending_o !== 4'b0110 || err_o !== 1'b0) begin errors++; $display("FAIL conc_pre: got dest %0d pend %b err %b exp 2 0110 0", b_dest_o, pending_o, err_o); end
    tick();
    ack_valid_i = 1'b0; b_ready_i = 1'b0; #1;
    checks++; if (pending_o !== 4'b0100 || b_valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL conc_post: got pend %b v %b busy %b exp 0100 0 1", pending_o, b_valid_o, busy_o); end
    start_i = 1'b1; start_mask_i = 4'b1111; #1;
    checks++; if (start_ready_o !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b exp 0", start_ready_o); end
    tick();
    start_i = 1'b0; #1;
    checks++; if (pending_o !== 4'b0100 || b_valid_o !== 1'b0) begin errors++; $display("FAIL busy_ignore: got pend %b v %b exp 0100 0", pending_o, b_valid_o); end
    ack_valid_i = 1'b1; ack_id_i = 2'd2;
    tick();
    ack_valid_i = 1'b0; #1;
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL conc_done: got %b exp 1", done_o); end
    tick();
  endtask

  task automatic test_reset_mid_round();
    start_i = 1'b1; start_mask_i = 4'b1000; start_addr_i = 64'h77; start_param_i = 2'd1;
    b_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    checks++; if (pending_o !== 4'b1000 || b_valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL mid_wait: got pend %b v %b busy %b exp 1000 0 1", pending_o, b_valid_o, busy_o); end
    rst_ni = 1'b0; #1;
    checks++; if (pending_o !== 4'b0000 || busy_o !== 1'b0 || start_ready_o !== 1'b1 || b_address_o !== 64'h0 || b_param_o !== 2'd0) begin errors++; $display("FAIL mid_async: got pend %b busy %b rdy %b addr %h par %0d exp 0000 0 1 0 0", pending_o, busy_o, start_ready_o, b_address_o, b_param_o); end
    tick();
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL mid_nodone%0d: got done %b busy %b exp 0 0", c, done_o, busy_o); end
    end
    start_i = 1'b1; start_mask_i = 4'b0001; b_ready_i = 1'b0;
    tick();
    start_i = 1'b0; #1;
    checks++; if (b_valid_o !== 1'b1 || b_dest_o !== 2'd0 || pending_o !== 4'b0001) begin errors++; $display("FAIL mid_restart: got v %b dest %0d pend %b exp 1 0 0001", b_valid_o, b_dest_o, pending_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_mask();
    test_spurious_and_concurrent();
    test_reset_mid_round();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
